// File: rtl/ipc_msg_arbiter.sv
// Round-robin arbiter that moves whole nul-terminated IPC messages from NUM_SRC
// source FIFOs into one consumer FIFO, aborting a message whose source starves.
module ipc_msg_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int TOKEN_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_SRC*TOKEN_WIDTH-1:0] SRC_DATA,
    input  logic [NUM_SRC-1:0]             SRC_EMPTY,
    output logic [NUM_SRC-1:0]             SRC_RD_EN,
    output logic [TOKEN_WIDTH-1:0]         OUT_DATA,
    output logic                           OUT_WR_EN,
    input  logic                           OUT_FULL,
    output logic [NUM_SRC-1:0]             GRANT,
    output logic                           TIMEOUT_ERR,
    output logic [15:0]                    TIMEOUT_COUNT,
    output logic [2:0]                     dbg_state
);

    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TMR_REQ = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMR_W   = (TMR_REQ > 16) ? TMR_REQ : 16;

    // Handshakes: SRC_RD_EN[g] is a one-cycle pop strobe, the popped token is
    // on SRC_DATA the following cycle; OUT_WR_EN is a one-cycle push strobe
    // that is only raised when OUT_FULL was low on the deciding edge
    // (FETCH/ABORT), so at most one read and one write are ever in flight.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        ABORT   = 3'd4
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         owner;
    logic [IDX_W-1:0]         last_grant;
    logic [TMR_W-1:0]         timer;
    logic [IDX_W-1:0]         pick;
    logic                     pick_valid;
    logic [TOKEN_WIDTH-1:0]   cur_tok;
    logic                     owner_empty;
    logic                     backpressure;

    assign dbg_state    = state;
    assign cur_tok      = SRC_DATA[int'(owner)*TOKEN_WIDTH +: TOKEN_WIDTH];
    assign owner_empty  = SRC_EMPTY[owner];
    assign backpressure = OUT_FULL || OUT_WR_EN;

    // First non-empty source after the previous owner, wrapping around.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last_grant) + i) % NUM_SRC);
            if (!pick_valid && !SRC_EMPTY[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            owner         <= '0;
            last_grant    <= IDX_W'(NUM_SRC - 1);
            timer         <= '0;
            GRANT         <= '0;
            SRC_RD_EN     <= '0;
            OUT_DATA      <= '0;
            OUT_WR_EN     <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
            TIMEOUT_COUNT <= '0;
        end else begin
            SRC_RD_EN   <= '0;
            OUT_WR_EN   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick;
                        GRANT <= NUM_SRC'(1) << pick;
                        timer <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!owner_empty && !backpressure) begin
                        SRC_RD_EN <= NUM_SRC'(1) << owner;
                        state     <= WAIT;
                    end else if (owner_empty && !backpressure) begin
                        // Only true starvation advances the timer; the wide
                        // timer guarantees it reaches the limit without wrapping.
                        timer <= timer + 1'b1;
                        if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            state <= ABORT;
                        end
                    end
                end
                WAIT: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    OUT_DATA  <= cur_tok;
                    OUT_WR_EN <= 1'b1;
                    timer     <= '0;
                    if (cur_tok == '0) begin
                        last_grant <= owner;
                        GRANT      <= '0;
                        state      <= IDLE;
                    end else begin
                        state <= FETCH;
                    end
                end
                ABORT: begin
                    if (!backpressure) begin
                        OUT_DATA    <= '0;
                        OUT_WR_EN   <= 1'b1;
                        TIMEOUT_ERR <= 1'b1;
                        if (TIMEOUT_COUNT != 16'hFFFF) begin
                            TIMEOUT_COUNT <= TIMEOUT_COUNT + 16'd1;
                        end
                        last_grant  <= owner;
                        GRANT       <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipc_msg_arbiter.sv
// Bench for ipc_msg_arbiter: behavioural source/consumer FIFOs, a round-robin
// message-level reference model, and directed scenarios for the corner cases.
module tb_ipc_msg_arbiter;

    localparam int NS = 4;
    localparam int TW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NS*TW-1:0]  SRC_DATA;
    logic [NS-1:0]     SRC_EMPTY;
    logic [NS-1:0]     SRC_RD_EN;
    logic [TW-1:0]     OUT_DATA;
    logic              OUT_WR_EN;
    logic              OUT_FULL;
    logic [NS-1:0]     GRANT;
    logic              TIMEOUT_ERR;
    logic [15:0]       TIMEOUT_COUNT;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    ipc_msg_arbiter #(.NUM_SRC(NS), .TOKEN_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .SRC_DATA(SRC_DATA), .SRC_EMPTY(SRC_EMPTY),
        .SRC_RD_EN(SRC_RD_EN), .OUT_DATA(OUT_DATA), .OUT_WR_EN(OUT_WR_EN),
        .OUT_FULL(OUT_FULL), .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR),
        .TIMEOUT_COUNT(TIMEOUT_COUNT), .dbg_state(dbg_state)
    );

    logic [TW-1:0] src_q[NS][$];
    logic [TW-1:0] obs_q[$];
    logic [TW-1:0] exp_q[$];
    int            obs_cyc[$];
    int            cyc;
    int            err_pulses;
    int            viol;
    int            n_tests;
    int            n_fail;
    bit            auto_full;
    int            full_hold;

    // One clock step, sampled on the falling edge: invariants, consumer capture,
    // source FIFO pops and optional random consumer backpressure.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!$onehot0(GRANT)) viol++;
        if (!$onehot0(SRC_RD_EN)) viol++;
        if ((SRC_RD_EN & ~GRANT) != '0) viol++;
        if ((SRC_RD_EN & SRC_EMPTY) != '0) viol++;
        if (OUT_WR_EN && OUT_FULL) viol++;
        if (OUT_WR_EN) begin
            obs_q.push_back(OUT_DATA);
            obs_cyc.push_back(cyc);
        end
        if (TIMEOUT_ERR) err_pulses++;
        for (int i = 0; i < NS; i++) begin
            if (SRC_RD_EN[i]) begin
                if (src_q[i].size() > 0) SRC_DATA[i*TW +: TW] = src_q[i].pop_front();
                else viol++;
            end
            SRC_EMPTY[i] = (src_q[i].size() == 0);
        end
        if (auto_full) begin
            if (full_hold > 0) begin
                full_hold--;
                if (full_hold == 0) OUT_FULL = 1'b0;
            end else if (OUT_WR_EN && $urandom_range(0, 1) == 1) begin
                OUT_FULL  = 1'b1;
                full_hold = $urandom_range(1, 6);
            end
        end
    endtask

    task automatic push_tok(input int s, input logic [TW-1:0] t);
        src_q[s].push_back(t);
        SRC_EMPTY[s] = 1'b0;
    endtask

    function automatic logic [TW-1:0] rand_tok(input int s);
        return {8'hA0 + 8'(s), 24'($urandom_range(1, 24'hFFFFFF))};
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        OUT_FULL  = 1'b0;
        auto_full = 1'b0;
        full_hold = 0;
        SRC_DATA  = '0;
        SRC_EMPTY = '1;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        tick();
        tick();
        resetn = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
        err_pulses = 0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (obs_q.size() < n) begin
            n_fail++;
            $display("FAIL %s: got %0d writes, required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic compare_stream(input string name);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d tokens, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h, required %h", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_tests++;
        if ({GRANT, SRC_RD_EN, OUT_WR_EN, TIMEOUT_ERR} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b rd=%b wr=%b err=%b, required all 0",
                     GRANT, SRC_RD_EN, OUT_WR_EN, TIMEOUT_ERR);
        end
        n_tests++;
        if (OUT_DATA !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", OUT_DATA);
        end
        n_tests++;
        if (TIMEOUT_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", TIMEOUT_COUNT);
        end
    endtask

    task automatic test_single_source();
        logic [TW-1:0] t_led, t_on;
        int bad_grant = 0;
        int k = 0;
        t_led = "led";
        t_on  = "on";
        do_reset();
        push_tok(2, t_led); push_tok(2, 32'd3); push_tok(2, t_on); push_tok(2, '0);
        exp_q = '{t_led, 32'd3, t_on, 32'd0};
        while (obs_q.size() < 4 && k < 200) begin
            tick();
            k++;
            if (obs_q.size() < 4 && GRANT !== 4'b0000 && GRANT !== 4'b0100) bad_grant++;
        end
        repeat (10) tick();
        compare_stream("single_tok");
        for (int i = 1; i < 4 && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
                n_fail++;
                $display("FAIL single_gap[%0d]: got %0d cycles, required 4", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        n_tests++;
        if (bad_grant != 0) begin
            n_fail++;
            $display("FAIL single_grant: got %0d cycles with foreign grant, required 0", bad_grant);
        end
        n_tests++;
        if (GRANT !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle_grant: got %b, required 0000", GRANT);
        end
    endtask

    task automatic test_all_sources();
        do_reset();
        exp_q.delete();
        for (int s = 0; s < NS; s++) begin
            logic [TW-1:0] t;
            t = rand_tok(s);
            push_tok(s, t);
            push_tok(s, '0);
            exp_q.push_back(t);
            exp_q.push_back('0);
        end
        wait_writes(2 * NS, 400, "all_src_wait");
        repeat (10) tick();
        compare_stream("all_src");
    endtask

    // Reference: pick the next non-empty source after the previous owner and
    // forward its whole message up to and including the nul.
    task automatic test_random_rr();
        for (int round = 0; round < 3; round++) begin
            logic [TW-1:0] m_q[NS][$];
            int last = NS - 1;
            bit any;
            do_reset();
            auto_full = 1'b1;
            exp_q.delete();
            for (int s = 0; s < NS; s++) begin
                int nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    int len = $urandom_range(0, 3);
                    for (int j = 0; j < len; j++) push_tok(s, rand_tok(s));
                    push_tok(s, '0);
                end
                m_q[s] = src_q[s];
            end
            any = 1'b1;
            while (any) begin
                any = 1'b0;
                for (int i = 1; i <= NS && !any; i++) begin
                    int s = (last + i) % NS;
                    if (m_q[s].size() > 0) begin
                        logic [TW-1:0] t;
                        any  = 1'b1;
                        last = s;
                        do begin
                            t = m_q[s].pop_front();
                            exp_q.push_back(t);
                        end while (t != '0);
                    end
                end
            end
            wait_writes(exp_q.size(), 8000, "rand_wait");
            repeat (20) tick();
            compare_stream("rand_rr");
        end
        auto_full = 1'b0;
        OUT_FULL  = 1'b0;
    endtask

    task automatic test_backpressure();
        int nw;
        do_reset();
        exp_q = '{rand_tok(0), rand_tok(0), rand_tok(0), 32'd0};
        foreach (exp_q[i]) push_tok(0, exp_q[i]);
        wait_writes(1, 100, "bp_first");
        OUT_FULL = 1'b1;
        nw = obs_q.size();
        repeat (5000) tick();
        n_tests++;
        if (obs_q.size() != nw) begin
            n_fail++;
            $display("FAIL bp_no_write: got %0d writes, required %0d", obs_q.size(), nw);
        end
        n_tests++;
        if (err_pulses != 0 || TIMEOUT_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL bp_no_timeout: got err=%0d count=%0d, required 0/0", err_pulses, TIMEOUT_COUNT);
        end
        n_tests++;
        if (GRANT !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_grant_held: got %b, required 0001", GRANT);
        end
        OUT_FULL = 1'b0;
        wait_writes(4, 100, "bp_resume");
        repeat (5) tick();
        compare_stream("bp_tok");
    endtask

    task automatic test_timeout();
        logic [TW-1:0] t;
        int gap;
        do_reset();
        t = rand_tok(1);
        push_tok(1, t);
        exp_q = '{t, 32'd0};
        wait_writes(2, 200, "to_wait");
        repeat (5) tick();
        compare_stream("to_tok");
        gap = (obs_cyc.size() >= 2) ? obs_cyc[1] - obs_cyc[0] : 0;
        n_tests++;
        if (gap < TO || gap > TO + 4) begin
            n_fail++;
            $display("FAIL to_gap: got %0d cycles, required %0d..%0d", gap, TO, TO + 4);
        end
        n_tests++;
        if (err_pulses != 1) begin
            n_fail++;
            $display("FAIL to_err_pulse: got %0d pulses, required 1", err_pulses);
        end
        n_tests++;
        if (TIMEOUT_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL to_count: got %0d, required 1", TIMEOUT_COUNT);
        end
        n_tests++;
        if (GRANT !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_grant: got %b, required 0000", GRANT);
        end
    endtask

    task automatic test_reset_mid();
        logic [TW-1:0] p, q, r;
        int k = 0;
        do_reset();
        p = rand_tok(2); q = rand_tok(2); r = rand_tok(0);
        push_tok(2, p); push_tok(2, q); push_tok(2, '0);
        while (SRC_RD_EN == '0 && k < 50) begin
            tick();
            k++;
        end
        n_tests++;
        if (SRC_RD_EN !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_rd_seen: got %b, required 0100", SRC_RD_EN);
        end
        resetn = 1'b0;
        tick();
        n_tests++;
        if ({GRANT, SRC_RD_EN, OUT_WR_EN, TIMEOUT_ERR, OUT_DATA, TIMEOUT_COUNT} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got grant=%b rd=%b wr=%b err=%b data=%h cnt=%0d, required all 0",
                     GRANT, SRC_RD_EN, OUT_WR_EN, TIMEOUT_ERR, OUT_DATA, TIMEOUT_COUNT);
        end
        resetn = 1'b1;
        push_tok(0, r); push_tok(0, '0);
        k = 0;
        while (GRANT == '0 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (GRANT !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_first_grant: got %b, required 0001", GRANT);
        end
        exp_q = '{r, 32'd0, q, 32'd0};
        wait_writes(4, 200, "mid_wait");
        repeat (5) tick();
        compare_stream("mid_tok");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        viol    = 0;
        cyc     = 0;
        test_reset();
        test_single_source();
        test_all_sources();
        test_random_rr();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL invariants: got %0d violating cycles, required 0", viol);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipc_msg_arbiter.md
IPC_MSG_ARBITER -- requirements
Module: ipc_msg_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of token-source FIFOs sharing one consumer FIFO.
REQ-002 Parameter TOKEN_WIDTH, default 128: IPC token width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: allowed starvation cycles before a granted message is aborted.
REQ-004 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 SRC_DATA  input  NUM_SRC*TOKEN_WIDTH  source read data; source i occupies bits [i*TOKEN_WIDTH +: TOKEN_WIDTH].
REQ-007 SRC_EMPTY  input  NUM_SRC  per-source FIFO empty flag.
REQ-008 SRC_RD_EN  output  NUM_SRC  per-source read strobe; source data is valid the cycle after the strobe.
REQ-009 OUT_DATA  output  TOKEN_WIDTH  token written to the consumer FIFO.
REQ-010 OUT_WR_EN  output  1  consumer FIFO write strobe.
REQ-011 OUT_FULL  input  1  consumer FIFO full flag.
REQ-012 GRANT  output  NUM_SRC  one-hot owner of the current message; all zero when idle.
REQ-013 TIMEOUT_ERR  output  1  single-cycle pulse on message abort.
REQ-014 TIMEOUT_COUNT  output  16  saturating count of aborted messages.

Function
REQ-015 A message SHALL be a token sequence ending with an all-zero (nul) token; messages SHALL be forwarded atomically, never interleaved.
REQ-016 States SHALL be IDLE, FETCH, WAIT, CAPTURE and ABORT; all outputs SHALL be registered.
REQ-017 IDLE: if any SRC_EMPTY bit is 0, grant the first non-empty source searching from (last_grant+1) mod NUM_SRC upward with wrap. Set GRANT one-hot, clear the timer, go to FETCH.
REQ-018 FETCH: if SRC_EMPTY[g]==0, OUT_FULL==0 and OUT_WR_EN==0, drive SRC_RD_EN[g]=1 for exactly the next cycle and go to WAIT.
REQ-019 FETCH otherwise: stay in FETCH. The timer SHALL increment only on cycles with SRC_EMPTY[g]==1; backpressure cycles (OUT_FULL or OUT_WR_EN high) SHALL hold it.
REQ-020 FETCH: when the timer reaches TIMEOUT_CYCLES, go to ABORT.
REQ-021 WAIT: the cycle in which SRC_RD_EN[g] is high; go to CAPTURE unconditionally.
REQ-022 CAPTURE: latch SRC_DATA slice g into OUT_DATA, drive OUT_WR_EN=1 for exactly the next cycle, and clear the timer.
REQ-023 CAPTURE, token nul: set last_grant=g, clear GRANT, go to IDLE. Token non-nul: go to FETCH.
REQ-024 ABORT: when OUT_FULL==0 and OUT_WR_EN==0, write an all-zero token to the consumer. In the same cycle, pulse TIMEOUT_ERR, increment TIMEOUT_COUNT (saturating at 16'hFFFF), set last_grant=g, clear GRANT and go to IDLE; otherwise wait in ABORT.
REQ-025 Steady-state throughput SHALL be one token per 4 cycles; SRC_RD_EN SHALL never assert for a non-granted source or while SRC_EMPTY[g]==1.
REQ-026 At most one SRC_RD_EN bit and at most one outstanding consumer write SHALL exist at any time.
REQ-027 Sources going non-empty during a granted message SHALL be ignored until that message completes or aborts.
REQ-028 The timer SHALL be at least 16 bits wide and SHALL NOT wrap before reaching TIMEOUT_CYCLES.

Reset
REQ-029 When resetn is low: state=IDLE, GRANT=0, SRC_RD_EN=0, OUT_WR_EN=0, OUT_DATA=0, TIMEOUT_ERR=0, TIMEOUT_COUNT=0, timer=0, last_grant=NUM_SRC-1 (source 0 wins first).
REQ-030 Reset mid-message SHALL abandon the message without writing a nul token; the partial message is the system's responsibility.

Verification
REQ-031 Source 2 holds "led",3,"on",nul; others empty; OUT_FULL=0 -> exactly 4 OUT_WR_EN pulses, 4 cycles apart, tokens in order. GRANT=4'b0100 throughout, then 0.
REQ-032 All four sources each hold a 2-token message from reset -> messages emitted in order src0, src1, src2, src3, each contiguous with no interleaving.
REQ-033 OUT_FULL held high for 5000 cycles mid-message with the source non-empty -> no writes, no timeout; the transfer resumes after OUT_FULL falls.
REQ-034 Source 1 supplies one non-nul token then stays empty; TIMEOUT_CYCLES=16 -> nul written 16 starvation cycles later, TIMEOUT_ERR pulses once, TIMEOUT_COUNT=1, GRANT=0.
REQ-035 resetn low for 1 cycle while a message is in WAIT -> next cycle all outputs at reset values; a following message from source 0 is granted first.
REQ-036 Assertions over all tests: GRANT one-hot or zero; SRC_RD_EN a subset of GRANT; never SRC_RD_EN while SRC_EMPTY; never OUT_WR_EN while OUT_FULL was high the prior cycle.
